// File: rtl/vote_pkg.sv
// Shared types and constants for the 4-voter ballot front end.
// Voter count, verdict encodings and controller state enum.
package vote_pkg;

  localparam int N_VOTERS = 4;

  localparam logic [2:0] RES_FAIL = 3'b100;
  localparam logic [2:0] RES_TIE  = 3'b010;
  localparam logic [2:0] RES_PASS = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    EVAL = 2'd2
  } state_e;

endpackage

// File: rtl/vote_ballot_ctrl.sv
// Ballot controller: opens a timed window, latches first votes,
// then captures the evaluator verdict for one cycle of EVAL.
module vote_ballot_ctrl
  import vote_pkg::*;
#(
  parameter int WINDOW_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic [N_VOTERS-1:0] ballot,
  input  logic [2:0]          eval_result,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic [2:0]          result,
  output logic                done,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WINDOW_CYCLES - 1);

  state_e              state_q, state_d;
  logic [N_VOTERS-1:0] ballot_q, ballot_d;
  logic [N_VOTERS-1:0] mask_q, mask_d;
  logic [N_VOTERS-1:0] fresh;
  logic [2:0]          result_q, result_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    mask_d   = mask_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    fresh    = vote_valid & ~mask_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = OPEN;
          ballot_d = '0;
          mask_d   = '0;
          err_d    = 1'b0;
          result_d = '0;
          cnt_d    = CNT_LOAD;
        end
      end
      OPEN: begin
        // only voters not yet latched may write their bit
        ballot_d = (ballot_q & ~fresh) | (vote_val & fresh);
        mask_d   = mask_q | fresh;
        if (&mask_d || cnt_q == '0) begin
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EVAL: begin
        result_d = eval_result;
        err_d    = !$onehot(eval_result);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ballot_q <= '0;
      mask_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ballot_q <= ballot_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = (state_q == OPEN) || (state_q == EVAL);
  assign ballot     = ballot_q;
  assign voted_mask = mask_q;
  assign result     = result_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
// Bench for vote_ballot_ctrl with an evaluator stub and a
// window-level reference model compared on every negedge.
module tb_vote_ballot_ctrl;
  import vote_pkg::*;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vote_valid = '0;
  logic [3:0] vote_val = '0;
  logic [3:0] ballot;
  logic [2:0] eval_result;
  logic       busy;
  logic [3:0] voted_mask;
  logic [2:0] result;
  logic       done;
  logic       err;

  logic       force_en = 1'b0;
  logic [2:0] force_val = '0;

  int n_vec = 0;
  int errs = 0;
  bit chk_en = 0;

  vote_ballot_ctrl #(.WINDOW_CYCLES(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vote_valid(vote_valid), .vote_val(vote_val),
    .ballot(ballot), .eval_result(eval_result),
    .busy(busy), .voted_mask(voted_mask),
    .result(result), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] verdict(input logic [3:0] b);
    int yes;
    yes = $countones(b);
    if (yes <= 1) return RES_FAIL;
    if (yes == 2) return RES_TIE;
    return RES_PASS;
  endfunction

  // evaluator stub, overridable to inject a bad verdict
  always_comb begin
    eval_result = force_en ? force_val : verdict(ballot);
  end

  // reference model: window tracked as elapsed cycles since start
  bit         m_open, m_eval, m_done, m_err;
  int         m_elapsed;
  logic [3:0] m_ballot, m_mask;
  logic [2:0] m_result, m_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_open = 0; m_eval = 0; m_done = 0; m_err = 0;
      m_elapsed = 0; m_ballot = '0; m_mask = '0;
      m_result = '0;
    end else begin
      m_done = 0;
      if (m_eval) begin
        m_v = force_en ? force_val : verdict(m_ballot);
        m_result = m_v;
        m_err = ($countones(m_v) != 1);
        m_done = 1;
        m_eval = 0;
      end else if (m_open) begin
        for (int i = 0; i < 4; i++) begin
          if (vote_valid[i] && !m_mask[i]) begin
            m_mask[i] = 1'b1;
            m_ballot[i] = vote_val[i];
          end
        end
        m_elapsed++;
        if (m_mask == 4'hf || m_elapsed == W) begin
          m_open = 0;
          m_eval = 1;
        end
      end else if (start) begin
        m_open = 1; m_elapsed = 0;
        m_ballot = '0; m_mask = '0;
        m_err = 0; m_result = '0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", 32'(busy), 32'(m_open | m_eval));
      chk("m_ballot", 32'(ballot), 32'(m_ballot));
      chk("m_mask", 32'(voted_mask), 32'(m_mask));
      chk("m_result", 32'(result), 32'(m_result));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_err", 32'(err), 32'(m_err));
    end
  end

  logic [3:0] vv_tab [0:31];
  logic [3:0] vl_tab [0:31];
  logic       st_tab [0:31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tabs();
    for (int i = 0; i < 32; i++) begin
      vv_tab[i] = '0; vl_tab[i] = '0; st_tab[i] = 1'b0;
    end
  endtask

  // start on edge 0, then drive table entries for edges 1..;
  // donek = edge index at which done was seen, -1 on timeout
  task automatic run(output int donek);
    donek = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 32; k++) begin
      vote_valid = vv_tab[k];
      vote_val   = vl_tab[k];
      start      = st_tab[k];
      tick();
      if (done) begin
        donek = k;
        break;
      end
    end
    vote_valid = '0; vote_val = '0; start = 1'b0;
  endtask

  int dk;

  initial begin
    rst_n = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_ballot", 32'(ballot), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // all four at once, 1011 -> pass
    clr_tabs();
    vv_tab[1] = 4'hf; vl_tab[1] = 4'b1011;
    run(dk);
    chk("t1_lat", 32'(dk), 32'd2);
    chk("t1_ballot", 32'(ballot), 32'hb);
    chk("t1_result", 32'(result), 32'(3'b001));
    tick();
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_done_pulse", 32'(done), 32'h0);

    // voters 0 and 2 then timeout -> tie
    clr_tabs();
    vv_tab[2] = 4'b0001; vl_tab[2] = 4'b0001;
    vv_tab[5] = 4'b0100; vl_tab[5] = 4'b0100;
    run(dk);
    chk("t2_lat", 32'(dk), 32'd17);
    chk("t2_ballot", 32'(ballot), 32'h5);
    chk("t2_mask", 32'(voted_mask), 32'h5);
    chk("t2_result", 32'(result), 32'(3'b010));
    tick();

    // first response wins for voter 1
    clr_tabs();
    vv_tab[1] = 4'b0010; vl_tab[1] = 4'b0010;
    vv_tab[3] = 4'b0010; vl_tab[3] = 4'b0000;
    vv_tab[4] = 4'b0010; vl_tab[4] = 4'b0000;
    vv_tab[6] = 4'b1000; vl_tab[6] = 4'b1000;
    run(dk);
    chk("t3_lat", 32'(dk), 32'd17);
    chk("t3_ballot", 32'(ballot), 32'ha);
    chk("t3_result", 32'(result), 32'(3'b010));
    tick();

    // start during OPEN ignored; strobes in IDLE ignored
    clr_tabs();
    vv_tab[2] = 4'b0001; vl_tab[2] = 4'b0001;
    st_tab[3] = 1'b1;
    st_tab[9] = 1'b1;
    run(dk);
    chk("t4_lat", 32'(dk), 32'd17);
    chk("t4_result", 32'(result), 32'(3'b100));
    vote_valid = 4'hf; vote_val = 4'hf;
    repeat (3) tick();
    vote_valid = '0; vote_val = '0;
    chk("t4_idle_mask", 32'(voted_mask), 32'h1);
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // reset mid-window aborts without done
    start = 1'b1; tick(); start = 1'b0;
    vote_valid = 4'b0011; vote_val = 4'b0011; tick();
    vote_valid = '0; vote_val = '0;
    repeat (2) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_mask", 32'(voted_mask), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    repeat (20) begin
      tick();
      chk("t5_no_done", 32'(done), 32'h0);
    end
    clr_tabs();
    vv_tab[1] = 4'hf; vl_tab[1] = 4'hf;
    run(dk);
    chk("t5_lat", 32'(dk), 32'd2);
    chk("t5_result", 32'(result), 32'(3'b001));
    tick();

    // non-one-hot verdict flags err; next start clears it
    force_en = 1'b1; force_val = 3'b110;
    clr_tabs();
    vv_tab[1] = 4'hf; vl_tab[1] = 4'b0110;
    run(dk);
    chk("t6_result", 32'(result), 32'(3'b110));
    chk("t6_err", 32'(err), 32'h1);
    force_en = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_err_clr", 32'(err), 32'h0);
    chk("t6_res_clr", 32'(result), 32'h0);
    repeat (20) tick();
    chk("t6_end_res", 32'(result), 32'(3'b100));

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, errs);
    $finish;
  end

endmodule
